// File: rtl/axi_common_clock_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and programmable almost-full flag.
// Sits between the AES pipeline output and the S2MM stream master; prog_full throttles the upstream.
module axi_common_clock_fifo #(
  parameter int C_FIFO_DEPTH       = 256,
  parameter int C_PTR_WIDTH        = 8,
  parameter int C_DATA_WIDTH       = 129,
  parameter int C_PROG_FULL_THRESH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [C_DATA_WIDTH-1:0] din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [C_DATA_WIDTH-1:0] dout,
  output logic                    full,
  output logic                    empty,
  output logic                    prog_full,
  output logic [C_PTR_WIDTH:0]    data_count
);

  localparam logic [C_PTR_WIDTH:0]   DEPTH_CNT  = (C_PTR_WIDTH+1)'(C_FIFO_DEPTH);
  localparam logic [C_PTR_WIDTH:0]   THRESH_CNT = (C_PTR_WIDTH+1)'(C_PROG_FULL_THRESH);
  localparam logic [C_PTR_WIDTH:0]   CNT_ONE    = (C_PTR_WIDTH+1)'(1);
  localparam logic [C_PTR_WIDTH-1:0] PTR_ONE    = (C_PTR_WIDTH)'(1);

  logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [C_PTR_WIDTH-1:0]  wr_ptr;
  logic [C_PTR_WIDTH-1:0]  rd_ptr;
  logic [C_PTR_WIDTH:0]    count;
  logic                    wr_accept;
  logic                    rd_accept;

  // Acceptance uses the registered flags, so a write into a full FIFO is dropped
  // even when a read frees a slot in the same cycle.
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  // NOTE: the storage array has no reset; emptiness is tracked purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head word is presented directly from the array: no read-latency cycle.
  assign dout       = mem[rd_ptr];
  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign prog_full  = (count >= THRESH_CNT);
  assign data_count = count;

endmodule

// File: tb/tb_axi_common_clock_fifo.sv
// Self-checking bench for axi_common_clock_fifo: vector table, directed corner sequences,
// and a randomized run scored against a queue-based reference model.
module tb_axi_common_clock_fifo;

  localparam int DEPTH  = 256;
  localparam int DW     = 129;
  localparam int THRESH = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          prog_full;
  logic [8:0]    data_count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_q[$];

  axi_common_clock_fifo #(
    .C_FIFO_DEPTH      (DEPTH),
    .C_PTR_WIDTH       (8),
    .C_DATA_WIDTH      (DW),
    .C_PROG_FULL_THRESH(THRESH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .dout      (dout),
    .full      (full),
    .empty     (empty),
    .prog_full (prog_full),
    .data_count(data_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour: a plain queue of words, updated from the pre-edge occupancy.
  task automatic model_update(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    bit was_full, was_empty;
    if (r) begin
      model_q.delete();
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (rd && !was_empty) void'(model_q.pop_front());
      if (w && !was_full) model_q.push_back(d);
    end
  endtask

  // Drive inputs, take one edge, sample #1 later, advance the model.
  task automatic cycle(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    rst = r; wr_en = w; rd_en = rd; din = d;
    @(posedge clk);
    #1;
    model_update(r, w, rd, d);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = model_q.size();
    check({tag, "_count"}, DW'(data_count), DW'(n));
    check({tag, "_empty"}, DW'(empty), DW'(n == 0));
    check({tag, "_full"}, DW'(full), DW'(n == DEPTH));
    check({tag, "_prog_full"}, DW'(prog_full), DW'(n >= THRESH));
    if (n != 0) check({tag, "_dout"}, dout, model_q[0]);
  endtask

  function automatic logic [DW-1:0] rand_word(input int seq);
    logic [DW-1:0] w;
    w = {1'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'(seq)};
    return w;
  endfunction

  typedef struct {
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [8:0]    exp_count;
    logic          exp_empty;
    logic          exp_full;
    logic [DW-1:0] exp_dout;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  initial begin
    logic [DW-1:0] w_single;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    int seq;
    bit did_rst;

    w_single = 129'h1_0123456789ABCDEF0123456789ABCDEF;
    w_a      = 129'h0_AAAA0000AAAA0000AAAA0000AAAA0001;
    w_b      = 129'h1_BBBB0000BBBB0000BBBB0000BBBB0002;

    //          rst   wr    rd    din       cnt  emp   full  dout
    vecs[0]  = '{1'b1, 1'b0, 1'b0, '0,       9'd0, 1'b1, 1'b0, '0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, w_a,      9'd0, 1'b1, 1'b0, '0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, '0,       9'd0, 1'b1, 1'b0, '0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, '0,       9'd0, 1'b1, 1'b0, '0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, w_single, 9'd1, 1'b0, 1'b0, w_single};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, '0,       9'd1, 1'b0, 1'b0, w_single};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, '0,       9'd0, 1'b1, 1'b0, '0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, w_a,      9'd1, 1'b0, 1'b0, w_a};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, w_b,      9'd2, 1'b0, 1'b0, w_a};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, '0,       9'd1, 1'b0, 1'b0, w_b};
    vecs[10] = '{1'b0, 1'b0, 1'b1, '0,       9'd0, 1'b1, 1'b0, '0};

    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d_count", i), DW'(data_count), DW'(vecs[i].exp_count));
      check($sformatf("vec%0d_empty", i), DW'(empty), DW'(vecs[i].exp_empty));
      check($sformatf("vec%0d_full", i), DW'(full), DW'(vecs[i].exp_full));
      check($sformatf("vec%0d_prog_full", i), DW'(prog_full), '0);
      if (!vecs[i].exp_empty) check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // Fill 0..255: prog_full after the 128th write, full after the 256th.
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0, DW'(i));
      check($sformatf("fill%0d_prog_full", i), DW'(prog_full), DW'(i + 1 >= THRESH));
      check($sformatf("fill%0d_full", i), DW'(full), DW'(i + 1 == DEPTH));
      check_model("fill");
    end
    cycle(1'b0, 1'b1, 1'b0, DW'(999));
    check("overfill_count", DW'(data_count), DW'(256));
    check("overfill_full", DW'(full), DW'(1));

    // Drain: head must step 0..255; prog_full drops on the 128->127 transition.
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d_dout", i), dout, DW'(i));
      cycle(1'b0, 1'b0, 1'b1, '0);
      check($sformatf("drain%0d_prog_full", i), DW'(prog_full), DW'(DEPTH - 1 - i >= THRESH));
    end
    check("drain_empty", DW'(empty), DW'(1));
    check("drain_count", DW'(data_count), DW'(0));

    // Steady simultaneous access at count=10.
    seq = 1000;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, rand_word(seq++));
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b1, rand_word(seq++));
      check("simul10_count", DW'(data_count), DW'(10));
      check_model("simul10");
    end

    // Simultaneous access while full: read wins, write dropped.
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, rand_word(seq++));
    check("prefull_full", DW'(full), DW'(1));
    cycle(1'b0, 1'b1, 1'b1, DW'(777));
    check("fullboth_count", DW'(data_count), DW'(255));
    check_model("fullboth");
    for (int i = 0; i < 255; i++) begin
      cycle(1'b0, 1'b0, 1'b1, '0);
      check_model("fullboth_drain");
    end
    check("fullboth_drain_empty", DW'(empty), DW'(1));

    // Random traffic across pointer wraps with a reset once occupancy reaches 50.
    did_rst = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (!did_rst && model_q.size() == 50) begin
        cycle(1'b1, 1'b1, 1'b1, rand_word(seq++));
        did_rst = 1'b1;
        check("midrst_empty", DW'(empty), DW'(1));
        check("midrst_count", DW'(data_count), DW'(0));
      end else begin
        cycle(1'b0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), rand_word(seq++));
      end
      check_model("rand");
    end
    check("rand_reset_seen", DW'(did_rst), DW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
